// File: rtl/mem_stage_sram_ctrl_pkg.sv
// rtl/mem_stage_sram_ctrl_pkg.sv - shared types and constants for the memory-stage SRAM controller
package mem_stage_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - per-phase wait-state counter, done on the last cycle of a phase
module sram_wait_counter
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(SRAM_WAIT);

  logic [WAIT_CNT_W-1:0] cnt;

  // count cycles within a phase; load returns to zero for the next phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WAIT_CNT_W'(1);
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - 32-bit load/store as two 16-bit async SRAM accesses; LAST_STORE_FWD_EN adds last-store forwarding
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 1,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_AW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_Rm,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  state_t      state, state_nxt;
  logic [31:0] req_diff;
  logic [29:0] req_word;
  logic [29:0] lat_word;
  logic [31:0] lat_data;
  logic        cnt_load, cnt_en, cnt_done;
  logic        in_phase;
  logic        half;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        unused_bits;

  // modular offset from the SRAM base; byte offset within the word is dropped
  assign req_diff    = alu_res - BASE_ADDR;
  assign req_word    = req_diff[31:2];
  assign unused_bits = ^{req_diff[1:0], lat_word[29:SRAM_AW-1]};

`ifdef LAST_STORE_FWD_EN
  logic        buf_valid;
  logic [29:0] buf_word;
  logic [31:0] buf_data;

  assign fwd_hit  = mem_read_en & ~mem_write_en & buf_valid & (buf_word == req_word);
  assign fwd_data = buf_data;

  // capture a store only once its high half completes, so an aborted store never forwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
      buf_data  <= '0;
    end else if (state == ST_WR_HI && cnt_done) begin
      buf_valid <= 1'b1;
      buf_word  <= lat_word;
      buf_data  <= lat_data;
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 32'd0;
`endif

  sram_wait_counter #(
    .SRAM_WAIT(SRAM_WAIT)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .done (cnt_done)
  );

  // counter restarts at every phase boundary and while no phase is active
  assign cnt_load = ~in_phase | cnt_done;
  assign cnt_en   = in_phase & ~cnt_done;

  assign ready = (state == ST_DONE) |
                 ((state == ST_IDLE) & ~mem_read_en & ~mem_write_en);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // next state and SRAM strobes; we_n lifts on the last phase cycle for address/data hold
  always_comb begin
    state_nxt   = state;
    in_phase    = 1'b0;
    half        = HALF_LO;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'h0000;
    case (state)
      ST_IDLE: begin
        if (mem_write_en)     state_nxt = ST_WR_LO;
        else if (mem_read_en) state_nxt = fwd_hit ? ST_DONE : ST_RD_LO;
      end
      ST_RD_LO: begin
        in_phase  = 1'b1;
        sram_oe_n = 1'b0;
        if (cnt_done) state_nxt = ST_RD_HI;
      end
      ST_RD_HI: begin
        in_phase  = 1'b1;
        half      = HALF_HI;
        sram_oe_n = 1'b0;
        if (cnt_done) state_nxt = ST_DONE;
      end
      ST_WR_LO: begin
        in_phase    = 1'b1;
        sram_dq_oe  = 1'b1;
        sram_dq_out = lat_data[15:0];
        sram_we_n   = cnt_done;
        if (cnt_done) state_nxt = ST_WR_HI;
      end
      ST_WR_HI: begin
        in_phase    = 1'b1;
        half        = HALF_HI;
        sram_dq_oe  = 1'b1;
        sram_dq_out = lat_data[31:16];
        sram_we_n   = cnt_done;
        if (cnt_done) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    sram_addr = in_phase ? {lat_word[SRAM_AW-2:0], half} : '0;
  end

  // request latch and load result assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_word  <= '0;
      lat_data  <= '0;
      read_data <= '0;
    end else begin
      if (state == ST_IDLE && (mem_read_en | mem_write_en)) begin
        lat_word <= req_word;
        lat_data <= val_Rm;
        if (fwd_hit) read_data <= fwd_data;
      end
      if (state == ST_RD_LO && cnt_done) read_data[15:0]  <= sram_dq_in;
      if (state == ST_RD_HI && cnt_done) read_data[31:16] <= sram_dq_in;
    end
  end

endmodule
